// File: rtl/vga_timing.sv
// vga_timing: 1024x768@60 display timing generator, 65 MHz pixel clock.
// Ports: clk, rst (async active-low), en (pixel enable) in;
//        hcount/vcount, hblnk/vblnk, hsync/vsync, frame_start, frame_cnt out.
module vga_timing #(
    parameter int H_VISIBLE = 1024,
    parameter int H_FRONT   = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BACK    = 160,
    parameter int V_VISIBLE = 768,
    parameter int V_FRONT   = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 29,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hblnk,
    output logic        vblnk,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_BLANK  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);

    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_BLANK  = 10'(V_VISIBLE);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        fstart_q, fstart_d;
    logic [15:0] fcnt_q, fcnt_d;

    // Next counts first; every flag is decoded from these next counts so
    // that the registered flags line up exactly with the registered counts.
    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = 11'd0;
            if (vcount_q == V_LAST) begin
                vcount_d = 10'd0;
            end else begin
                vcount_d = vcount_q + 10'd1;
            end
        end

        hblnk_d = (hcount_d >= H_BLANK);
        vblnk_d = (vcount_d >= V_BLANK);

        hsync_d = ~HSYNC_POL;
        if (hcount_d >= HS_FIRST && hcount_d <= HS_LAST) begin
            hsync_d = HSYNC_POL;
        end

        vsync_d = ~VSYNC_POL;
        if (vcount_d >= VS_FIRST && vcount_d <= VS_LAST) begin
            vsync_d = VSYNC_POL;
        end

        // Only a counted wrap reaches (0,0) here; the reset state never
        // passes through this decode, so it produces no strobe.
        fstart_d = (hcount_d == 11'd0) && (vcount_d == 10'd0);
        fcnt_d   = fcnt_q + (fstart_d ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_q <= 11'd0;
            vcount_q <= 10'd0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            fstart_q <= 1'b0;
            fcnt_q   <= 16'd0;
        end else if (en) begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            fstart_q <= fstart_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fstart_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Display timing generator for the 1024x768@60 Hz video path, clocked from the 65 MHz pixel clock.
- Sits directly upstream of the menu and scene draw stages and feeds them hcount/vcount/hblnk/vblnk.
- Drives hsync/vsync, which the top level delays to match draw-stage latency.
- Also provides a start-of-frame strobe and a frame counter for animation and state-machine pacing.

Parameters:
- H_VISIBLE, 1024, active pixels per line
- H_FRONT, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BACK, 160, horizontal back porch (pixels); line total = 1344
- V_VISIBLE, 768, active lines per frame
- V_FRONT, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BACK, 29, vertical back porch (lines); frame total = 806
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level (0 = active-low)

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  reset; asynchronous, active-low
- en  in  1  pixel enable; when low, all state holds
- hcount  out  11  horizontal position, 0..H_TOTAL-1
- vcount  out  10  vertical position, 0..V_TOTAL-1
- hblnk  out  1  high when hcount >= H_VISIBLE
- vblnk  out  1  high when vcount >= V_VISIBLE
- hsync  out  1  horizontal sync at HSYNC_POL level
- vsync  out  1  vertical sync at VSYNC_POL level
- frame_start  out  1  one-cycle strobe when (hcount,vcount) becomes (0,0)
- frame_cnt  out  16  completed-frame counter, wraps

Behaviour:
- All outputs are registered.
- Every output is a function of the same registered (hcount,vcount) pair, so there is zero skew between counts, blanking and syncs.
- Decode: the next-state counts are computed combinationally; hblnk/vblnk/hsync/vsync/frame_start are decoded from those next counts and registered in the same edge as the counts.
- Reset (rst low, asynchronous) forces: hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, frame_start=0, frame_cnt=0.
- Release is sampled on the next clk rising edge.
- Horizontal counter: on each clk edge with en=1, hcount increments. At H_TOTAL-1 it wraps to 0, and vcount advances on that same edge.
- Vertical counter: advances only on the hcount wrap; at V_TOTAL-1 it wraps to 0 on the same edge that hcount wraps.
- hsync is active for hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [1048, 1183].
- vsync is active for vcount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [771, 776]. vsync is line-aligned: it changes with vcount on the hcount wrap edge.
- hblnk is set for hcount in [1024, 1343]. vblnk is set for vcount in [768, 805]. Both are independent of each other.
- frame_start:
  - Pulses high for exactly one enabled cycle, the one in which the outputs show (0,0) after a wrap.
  - The reset state (0,0) does not produce a pulse; the first frame_start comes 1344*806 = 1,083,264 enabled cycles after reset release.
  - If en drops while frame_start=1, frame_start stays high until the next enabled edge.
- frame_cnt:
  - Increments by 1 on the same edge frame_start rises.
  - Modulo 2^16: 16'hFFFF -> 16'h0000, with no flag.
- en=0: hcount, vcount and every decoded output hold their values. Blanking and sync levels must not glitch while stalled.
- Widths:
  - hcount needs 11 bits (max 1343).
  - vcount needs 10 bits (max 805).
  - Comparisons are unsigned.
  - Derived totals are localparams, not ports.
- Reset mid-frame: immediate return to the reset state on rst falling, with no partial-line completion. Counting restarts at (0,0) after release.
- Latency: one clock from the enabled edge to updated outputs. The draw stages must delay hsync/vsync by their own pipeline depth.

Test Plan:
- Reset release, en=1 held, count 1344 cycles -> hcount walks 0..1343 then 0; vcount goes 0->1 on that wrap edge; hblnk first high at hcount=1024.
- Observe a full line -> hsync low (POL=0) for exactly 136 cycles starting at hcount=1048; hsync high at 1047 and 1184.
- Run 806 lines -> vsync low for lines 771..776 (6*1344 = 8064 cycles); vblnk high for vcount 768..805; vcount wraps 805->0 coincident with hcount 1343->0.
- Run 3 frames -> frame_start high exactly 3 times, each one cycle at (0,0), spaced 1,083,264 cycles apart; frame_cnt reads 1, 2, 3; no pulse at reset.
- Toggle en low for 50 cycles at hcount=1183 -> all outputs frozen (hsync still active); after en=1, next edge gives hcount=1184 with hsync inactive.
- Assert rst low at hcount=700, vcount=400 between clock edges -> outputs reach reset values immediately (asynchronous); after release, hcount=1 one edge later. Separately, preload frame_cnt near wrap by running 65536 frames (or force) -> 16'hFFFF -> 16'h0000.
